// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared constants and types for the sfifo buffer.
// Data is DATA_WIDTH bits; pointers carry one extra wrap bit above the address.
package sfifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 64;
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH:0]   ptr_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/sfifo_ram.sv
// sfifo_ram: DEPTH x DATA_WIDTH simple dual-port storage.
// Ports: clk, rst (clears rdata only), we/waddr/wdata (sync write),
//        re/raddr (sync read), rdata (registered, holds when re=0).
module sfifo_ram
    import sfifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata,
    input  logic  re,
    input  addr_t raddr,
    output data_t rdata
);

    data_t mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sfifo.sv
// sfifo: single-clock FIFO with full/empty and one-cycle error pulses.
// Ports: rst, clk, w_en, din, r_en, dout (registered), full, empty,
//        overflow, underflow; level added when SFIFO_LEVEL_EN is defined.
module sfifo
    import sfifo_pkg::*;
(
    input  logic  rst,
    input  logic  clk,
    input  logic  w_en,
    input  data_t din,
    input  logic  r_en,
    output data_t dout,
    output logic  full,
    output logic  empty,
    output logic  overflow,
    output logic  underflow
`ifdef SFIFO_LEVEL_EN
    ,
    output ptr_t  level
`endif
);

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    logic wr_ok;
    logic rd_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0])
                && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    // When full, a concurrent read frees the slot the write needs.
    // When empty, the read is rejected: no fall-through.
    assign wr_ok = w_en && (!full || r_en) && !rst;
    assign rd_ok = r_en && !empty && !rst;

`ifdef SFIFO_LEVEL_EN
    assign level = wr_ptr - rd_ptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            overflow  <= w_en && full && !r_en;
            underflow <= r_en && empty;
        end
    end

    sfifo_ram u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (din),
        .re    (rd_ok),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (dout)
    );

endmodule

// File: tb/tb_sfifo.sv
// tb_sfifo: directed scoreboard bench for sfifo.
// A queue model predicts acceptance, dout, flags and error pulses each cycle.
module tb_sfifo;
    import sfifo_pkg::*;

    logic  rst;
    logic  clk;
    logic  w_en;
    data_t din;
    logic  r_en;
    data_t dout;
    logic  full;
    logic  empty;
    logic  overflow;
    logic  underflow;
`ifdef SFIFO_LEVEL_EN
    ptr_t  level;
`endif

    int    total;
    int    passes;
    data_t q[$];
    data_t exp_dout;

    sfifo dut (
        .rst       (rst),
        .clk       (clk),
        .w_en      (w_en),
        .din       (din),
        .r_en      (r_en),
        .dout      (dout),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef SFIFO_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input logic e_ov, input logic e_un);
        chk("dout", 32'(dout), 32'(exp_dout));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("overflow", 32'(overflow), 32'(e_ov));
        chk("underflow", 32'(underflow), 32'(e_un));
`ifdef SFIFO_LEVEL_EN
        chk("level", 32'(level), 32'(q.size()));
`endif
    endtask

    task automatic do_reset(input int n);
        rst  = 1'b1;
        w_en = 1'bx;
        r_en = 1'bx;
        din  = '0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;
        q.delete();
        exp_dout = '0;
        check_all(1'b0, 1'b0);
    endtask

    // One cycle: drive, predict from pre-edge model state, sample at negedge.
    task automatic cyc(input logic w, input data_t d, input logic r);
        logic m_full;
        logic m_empty;
        logic e_ov;
        logic e_un;
        w_en    = w;
        din     = d;
        r_en    = r;
        m_full  = (q.size() == DEPTH);
        m_empty = (q.size() == 0);
        e_ov    = w && m_full && !r;
        e_un    = r && m_empty;
        if (r && !m_empty) exp_dout = q.pop_front();
        if (w && (!m_full || r)) q.push_back(d);
        @(posedge clk);
        @(negedge clk);
        w_en = 1'b0;
        r_en = 1'b0;
        check_all(e_ov, e_un);
    endtask

    initial begin
        total    = 0;
        passes   = 0;
        exp_dout = '0;
        rst      = 1'b1;
        w_en     = 1'b0;
        r_en     = 1'b0;
        din      = '0;

        do_reset(4);

        for (int i = 0; i < 64; i++) cyc(1'b1, data_t'(100 + i), 1'b0);

        cyc(1'b1, data_t'(164), 1'b0);
        cyc(1'b0, '0, 1'b0);

        for (int i = 0; i < 36; i++) cyc(1'b1, data_t'(200 + i), 1'b1);

        for (int i = 0; i < 80 && q.size() > 0; i++) cyc(1'b0, '0, 1'b1);
        chk("drained", 32'(q.size()), 32'd0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);

        cyc(1'b1, data_t'(55), 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);

        for (int i = 0; i < 32; i++) cyc(1'b1, data_t'(8'hA0 + i), 1'b0);
        cyc(1'b0, '0, 1'b1);
        do_reset(1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, data_t'(8'h3C), 1'b0);
        cyc(1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
